// File: rtl/ping_pong_scheduler_pkg.sv
// Shared types for the ping-pong scheduler.
//   sched_state_t : scheduler FSM encoding, also exported on the debug port.
//   Default widths for character address, seed word and in-flight counter.
package ping_pong_pkg;

  localparam int CHAR_ADDR_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF        = 16;
  localparam int INFLIGHT_WIDTH_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    RUN    = 3'd2,
    SWITCH = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/ping_pong_scheduler_if.sv
// Signal bundle between the scheduler and its environment (engines, FIFOs,
// controller).
//   master : environment side (drives start/bounds, FIFO status, engine events)
//   slave  : scheduler side (drives seed leg, pop_enable, select, status)
//
// Handshake: the seed word is transferred on a cycle where seed_valid and
// fifo_cur_char_data_in_ready are both high. Once raised, seed_valid and
// seed_data stay stable until that cycle; ready may toggle freely.
interface ping_pong_scheduler_if #(
  parameter int CAW = 16,
  parameter int PCW = 16
);
  import ping_pong_pkg::*;

  logic           start;
  logic [CAW-1:0] start_char_addr;
  logic [CAW-1:0] end_char_addr;
  logic [PCW-1:0] seed_pc;
  logic           seed_valid;
  logic [PCW-1:0] seed_data;
  logic           fifo_cur_char_data_in_ready;
  logic           fifo_cur_char_data_in_valid;
  logic           fifo_cur_char_data_out_valid;
  logic           fifo_next_char_data_out_valid;
  logic           engine_fetch;
  logic           engine_retire;
  logic           engine_accept;
  logic           pop_enable;
  logic           cur_is_even_character;
  logic [CAW-1:0] cur_char_addr;
  logic           busy;
  logic           done;
  logic           accepted;
  logic           inflight_error;
  sched_state_t   dbg_state;

  modport master (
    output start, start_char_addr, end_char_addr, seed_pc,
    output fifo_cur_char_data_in_ready, fifo_cur_char_data_in_valid,
    output fifo_cur_char_data_out_valid, fifo_next_char_data_out_valid,
    output engine_fetch, engine_retire, engine_accept,
    input  seed_valid, seed_data, pop_enable, cur_is_even_character,
    input  cur_char_addr, busy, done, accepted, inflight_error, dbg_state
  );

  modport slave (
    input  start, start_char_addr, end_char_addr, seed_pc,
    input  fifo_cur_char_data_in_ready, fifo_cur_char_data_in_valid,
    input  fifo_cur_char_data_out_valid, fifo_next_char_data_out_valid,
    input  engine_fetch, engine_retire, engine_accept,
    output seed_valid, seed_data, pop_enable, cur_is_even_character,
    output cur_char_addr, busy, done, accepted, inflight_error, dbg_state
  );

endinterface

// File: rtl/ping_pong_scheduler_inflight_tracker.sv
// Up/down counter of instructions fetched but not yet retired.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter and the error flag
//   inc, dec : one fetch / one retire this cycle (both together cancel)
//   count    : current outstanding instructions
//   error    : sticky; set on increment at max or decrement at zero
module inflight_tracker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         error
);

  logic [W-1:0] count_q, count_d;
  logic         error_q, error_d;

  always_comb begin
    count_d = count_q;
    error_d = error_q;
    if (clear) begin
      count_d = '0;
      error_d = 1'b0;
    end else if (inc && !dec) begin
      // Saturate rather than wrap so the drained test never sees a false zero.
      if (count_q == '1) error_d = 1'b1;
      else               count_d = count_q + W'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) error_d = 1'b1;
      else               count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign count = count_q;
  assign error = error_q;

endmodule

// File: rtl/ping_pong_scheduler.sv
// Sequences the even/odd ping-pong instruction FIFOs for one regex engine.
// Seeds the first instruction, lets engines pop the cur FIFO while the
// current character has work, and swaps cur/next once it is drained.
// Stops on accept, on an empty next FIFO, or after the last character.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ping_pong_scheduler_if.slave (control, FIFO status, engine
//              events in; seed leg, pop_enable, select, address, status
//              and FSM state out). All outputs are registered.
module ping_pong_scheduler
  import ping_pong_pkg::*;
#(
  parameter int CHAR_ADDR_WIDTH = 16,
  parameter int PC_WIDTH        = 16,
  parameter int INFLIGHT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ping_pong_scheduler_if.slave  bus
);

  sched_state_t               state_q, state_d;
  logic [CHAR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CHAR_ADDR_WIDTH-1:0] end_q, end_d;
  logic [PC_WIDTH-1:0]        seed_q, seed_d;
  logic                       sel_q, sel_d;
  logic                       seed_valid_q, seed_valid_d;
  logic                       pop_enable_q, pop_enable_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       accepted_q, accepted_d;

  logic                       start_accept;
  logic                       drained;
  logic [INFLIGHT_WIDTH-1:0]  inflight;
  logic                       inflight_err;

  assign start_accept = (state_q == IDLE) && bus.start;

  inflight_tracker #(.W(INFLIGHT_WIDTH)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .clear (start_accept),
    .inc   (bus.engine_fetch),
    .dec   (bus.engine_retire),
    .count (inflight),
    .error (inflight_err)
  );

  // The current character is finished only when nothing is queued, nothing
  // is in an engine, and nothing is about to be pushed or popped this cycle.
  assign drained = !bus.fifo_cur_char_data_out_valid &&
                   (inflight == '0) &&
                   !bus.fifo_cur_char_data_in_valid &&
                   !bus.engine_fetch;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    end_d        = end_q;
    seed_d       = seed_q;
    sel_d        = sel_q;
    seed_valid_d = seed_valid_q;
    pop_enable_d = pop_enable_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    accepted_d   = accepted_q;

    if (state_q != IDLE && state_q != DONE && bus.engine_accept) begin
      // Accept wins over everything else while a match is active.
      state_d      = DONE;
      done_d       = 1'b1;
      busy_d       = 1'b0;
      pop_enable_d = 1'b0;
      seed_valid_d = 1'b0;
      accepted_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d      = SEED;
            addr_d       = bus.start_char_addr;
            end_d        = bus.end_char_addr;
            seed_d       = bus.seed_pc;
            sel_d        = 1'b1;
            seed_valid_d = 1'b1;
            busy_d       = 1'b1;
            accepted_d   = 1'b0;
          end
        end
        SEED: begin
          if (seed_valid_q && bus.fifo_cur_char_data_in_ready) begin
            state_d      = RUN;
            seed_valid_d = 1'b0;
            pop_enable_d = 1'b1;
          end
        end
        RUN: begin
          if (drained) begin
            if (!bus.fifo_next_char_data_out_valid || addr_q == end_q) begin
              state_d      = DONE;
              done_d       = 1'b1;
              busy_d       = 1'b0;
              pop_enable_d = 1'b0;
              accepted_d   = 1'b0;
            end else begin
              state_d      = SWITCH;
              pop_enable_d = 1'b0;
            end
          end
        end
        SWITCH: begin
          // Address wraps naturally at the top of the address space.
          state_d      = RUN;
          sel_d        = !sel_q;
          addr_d       = addr_q + CHAR_ADDR_WIDTH'(1);
          pop_enable_d = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      end_q        <= '0;
      seed_q       <= '0;
      sel_q        <= 1'b1;
      seed_valid_q <= 1'b0;
      pop_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      accepted_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      end_q        <= end_d;
      seed_q       <= seed_d;
      sel_q        <= sel_d;
      seed_valid_q <= seed_valid_d;
      pop_enable_q <= pop_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      accepted_q   <= accepted_d;
    end
  end

  assign bus.seed_valid            = seed_valid_q;
  assign bus.seed_data             = seed_q;
  assign bus.pop_enable            = pop_enable_q;
  assign bus.cur_is_even_character = sel_q;
  assign bus.cur_char_addr         = addr_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
  assign bus.accepted              = accepted_q;
  assign bus.inflight_error        = inflight_err;
  assign bus.dbg_state             = state_q;

endmodule

// File: tb/tb_ping_pong_scheduler.sv
// Directed bench for ping_pong_scheduler: a table of per-cycle input
// vectors with hand-computed expected outputs, plus a hand-written
// in-flight overflow/underflow sequence with a bounded wait for done.
module tb_ping_pong_scheduler;
  import ping_pong_pkg::*;

  // Input bit positions: {rst,start,rdy,cin,cout,nout,fet,ret,acc}
  localparam logic [8:0] I_NONE  = 9'b000000000;
  localparam logic [8:0] I_RST   = 9'b100000000;
  localparam logic [8:0] I_START = 9'b010000000;
  localparam logic [8:0] I_RDY   = 9'b001000000;
  localparam logic [8:0] I_CIN   = 9'b000100000;
  localparam logic [8:0] I_COUT  = 9'b000010000;
  localparam logic [8:0] I_NOUT  = 9'b000001000;
  localparam logic [8:0] I_FET   = 9'b000000100;
  localparam logic [8:0] I_RET   = 9'b000000010;
  localparam logic [8:0] I_ACC   = 9'b000000001;

  // Expected status bits: {seed_valid,pop_enable,sel,busy,done,accepted,err}
  localparam logic [6:0] E_IDLE1 = 7'b0010000;
  localparam logic [6:0] E_IDLE0 = 7'b0000000;
  localparam logic [6:0] E_SEED  = 7'b1011000;
  localparam logic [6:0] E_RUN1  = 7'b0111000;
  localparam logic [6:0] E_RUN0  = 7'b0101000;
  localparam logic [6:0] E_SW1   = 7'b0011000;
  localparam logic [6:0] E_SW0   = 7'b0001000;
  localparam logic [6:0] E_DONE1 = 7'b0010100;
  localparam logic [6:0] E_DONE0 = 7'b0000100;

  typedef struct {
    logic [8:0]   in;
    logic [15:0]  sa;
    logic [15:0]  ea;
    logic [15:0]  pc;
    sched_state_t st;
    logic [6:0]   ex;
    logic [15:0]  sd;
    logic [15:0]  addr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ping_pong_scheduler_if #(.CAW(16), .PCW(16)) bus ();

  ping_pong_scheduler #(
    .CHAR_ADDR_WIDTH (16),
    .PC_WIDTH        (16),
    .INFLIGHT_WIDTH  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void add(logic [8:0] in, logic [15:0] sa, logic [15:0] ea,
                              logic [15:0] pc, sched_state_t st, logic [6:0] ex,
                              logic [15:0] sd, logic [15:0] addr);
    vec_t v;
    v.in = in; v.sa = sa; v.ea = ea; v.pc = pc;
    v.st = st; v.ex = ex; v.sd = sd; v.addr = addr;
    vecs.push_back(v);
  endfunction

  task automatic drive_in(input logic [8:0] in, input logic [15:0] sa,
                          input logic [15:0] ea, input logic [15:0] pc);
    rst                               = in[8];
    bus.start                         = in[7];
    bus.fifo_cur_char_data_in_ready   = in[6];
    bus.fifo_cur_char_data_in_valid   = in[5];
    bus.fifo_cur_char_data_out_valid  = in[4];
    bus.fifo_next_char_data_out_valid = in[3];
    bus.engine_fetch                  = in[2];
    bus.engine_retire                 = in[1];
    bus.engine_accept                 = in[0];
    bus.start_char_addr               = sa;
    bus.end_char_addr                 = ea;
    bus.seed_pc                       = pc;
  endtask

  task automatic step(input logic [8:0] in, input logic [15:0] sa,
                      input logic [15:0] ea, input logic [15:0] pc);
    drive_in(in, sa, ea, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] status();
    return {bus.seed_valid, bus.pop_enable, bus.cur_is_even_character,
            bus.busy, bus.done, bus.accepted, bus.inflight_error};
  endfunction

  initial begin
    drive_in(I_RST, 16'h0, 16'h0, 16'h0);

    // Reset
    add(I_RST,  0, 0, 0, IDLE, E_IDLE1, 16'h0, 16'h0);
    // A: no next work -> done from RUN, no SWITCH
    add(I_START,          0, 3, 16'h0010, SEED, E_SEED,  16'h0010, 0);
    add(I_RDY,            0, 0, 0,        RUN,  E_RUN1,  16'h0010, 0);
    add(I_COUT | I_FET,   0, 0, 0,        RUN,  E_RUN1,  16'h0010, 0);
    add(I_RET,            0, 0, 0,        RUN,  E_RUN1,  16'h0010, 0);
    add(I_NONE,           0, 0, 0,        DONE, E_DONE1, 16'h0010, 0);
    add(I_NONE,           0, 0, 0,        IDLE, E_IDLE1, 16'h0010, 0);
    // B: next FIFO always non-empty, end=3 -> three SWITCHes
    add(I_START,          0, 3, 16'h0020, SEED,   E_SEED,  16'h0020, 0);
    add(I_RDY,            0, 0, 0,        RUN,    E_RUN1,  16'h0020, 0);
    add(I_CIN | I_NOUT,   0, 0, 0,        RUN,    E_RUN1,  16'h0020, 0);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW1,   16'h0020, 0);
    add(I_NOUT,           0, 0, 0,        RUN,    E_RUN0,  16'h0020, 1);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW0,   16'h0020, 1);
    add(I_NOUT,           0, 0, 0,        RUN,    E_RUN1,  16'h0020, 2);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW1,   16'h0020, 2);
    add(I_NOUT,           0, 0, 0,        RUN,    E_RUN0,  16'h0020, 3);
    add(I_NOUT,           0, 0, 0,        DONE,   E_DONE0, 16'h0020, 3);
    add(I_NONE,           0, 0, 0,        IDLE,   E_IDLE0, 16'h0020, 3);
    // C: accept at char 2 with cur FIFO non-empty; accepted held in IDLE
    add(I_START,          0, 5, 16'h0030, SEED,   E_SEED,    16'h0030, 0);
    add(I_RDY,            0, 0, 0,        RUN,    E_RUN1,    16'h0030, 0);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW1,     16'h0030, 0);
    add(I_NONE,           0, 0, 0,        RUN,    E_RUN0,    16'h0030, 1);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW0,     16'h0030, 1);
    add(I_NONE,           0, 0, 0,        RUN,    E_RUN1,    16'h0030, 2);
    add(I_COUT | I_ACC,   0, 0, 0,        DONE,   7'b0010110, 16'h0030, 2);
    add(I_NONE,           0, 0, 0,        IDLE,   7'b0010010, 16'h0030, 2);
    // D: fetch+retire together with one in flight; underflow sets error
    add(I_START,                 0, 3, 16'h0040, SEED, E_SEED,     16'h0040, 0);
    add(I_RDY,                   0, 0, 0,        RUN,  E_RUN1,     16'h0040, 0);
    add(I_COUT | I_FET,          0, 0, 0,        RUN,  E_RUN1,     16'h0040, 0);
    add(I_COUT | I_FET | I_RET,  0, 0, 0,        RUN,  E_RUN1,     16'h0040, 0);
    add(I_NONE,                  0, 0, 0,        RUN,  E_RUN1,     16'h0040, 0);
    add(I_RET,                   0, 0, 0,        RUN,  E_RUN1,     16'h0040, 0);
    add(I_NONE,                  0, 0, 0,        DONE, E_DONE1,    16'h0040, 0);
    add(I_RET,                   0, 0, 0,        IDLE, 7'b0010001, 16'h0040, 0);
    add(I_NONE,                  0, 0, 0,        IDLE, 7'b0010001, 16'h0040, 0);
    // E: cur FIFO full for 5 seed cycles; start during SEED ignored
    add(I_START,          7, 7, 16'h0042, SEED, E_SEED,  16'h0042, 7);
    add(I_NONE,           0, 0, 0,        SEED, E_SEED,  16'h0042, 7);
    add(I_START,          9, 9, 16'h0099, SEED, E_SEED,  16'h0042, 7);
    add(I_NONE,           0, 0, 0,        SEED, E_SEED,  16'h0042, 7);
    add(I_NONE,           0, 0, 0,        SEED, E_SEED,  16'h0042, 7);
    add(I_RDY,            0, 0, 0,        RUN,  E_RUN1,  16'h0042, 7);
    add(I_NOUT,           0, 0, 0,        DONE, E_DONE1, 16'h0042, 7);
    add(I_NONE,           0, 0, 0,        IDLE, E_IDLE1, 16'h0042, 7);
    // F: address wraps 0xFFFF -> 0x0000, end reached after one SWITCH
    add(I_START, 16'hFFFF, 0, 16'h0050, SEED,   E_SEED,  16'h0050, 16'hFFFF);
    add(I_RDY,            0, 0, 0,        RUN,    E_RUN1,  16'h0050, 16'hFFFF);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW1,   16'h0050, 16'hFFFF);
    add(I_NONE,           0, 0, 0,        RUN,    E_RUN0,  16'h0050, 0);
    add(I_NOUT,           0, 0, 0,        DONE,   E_DONE0, 16'h0050, 0);
    add(I_NONE,           0, 0, 0,        IDLE,   E_IDLE0, 16'h0050, 0);
    // G: reset mid-RUN returns to reset values without a done pulse
    add(I_START,          5, 9, 16'h0060, SEED,   E_SEED,  16'h0060, 5);
    add(I_RDY,            0, 0, 0,        RUN,    E_RUN1,  16'h0060, 5);
    add(I_NOUT,           0, 0, 0,        SWITCH, E_SW1,   16'h0060, 5);
    add(I_NONE,           0, 0, 0,        RUN,    E_RUN0,  16'h0060, 6);
    add(I_RST | I_COUT,   0, 0, 0,        IDLE,   E_IDLE1, 16'h0000, 0);
    add(I_NONE,           0, 0, 0,        IDLE,   E_IDLE1, 16'h0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in, vecs[i].sa, vecs[i].ea, vecs[i].pc);
      total++;
      if (bus.dbg_state !== vecs[i].st || status() !== vecs[i].ex ||
          bus.seed_data !== vecs[i].sd || bus.cur_char_addr !== vecs[i].addr) begin
        bad++;
        $display("FAIL vec%0d: got st=%0d bits=%b seed=%h addr=%h want st=%0d bits=%b seed=%h addr=%h",
                 i, bus.dbg_state, status(), bus.seed_data, bus.cur_char_addr,
                 vecs[i].st, vecs[i].ex, vecs[i].sd, vecs[i].addr);
      end
    end

    // In-flight counter saturates at 15; the 16th fetch flags an error.
    step(I_START, 0, 0, 16'h0070);
    step(I_RDY, 0, 0, 0);
    check("ovf_run", 32'(bus.dbg_state), 32'(RUN));
    for (int i = 0; i < 15; i++) step(I_COUT | I_FET, 0, 0, 0);
    check("ovf_err_before", 32'(bus.inflight_error), 32'd0);
    step(I_COUT | I_FET, 0, 0, 0);
    check("ovf_err_after", 32'(bus.inflight_error), 32'd1);
    for (int i = 0; i < 15; i++) step(I_RET, 0, 0, 0);
    check("ovf_still_run", 32'(bus.dbg_state), 32'(RUN));
    begin
      int n;
      n = 0;
      while (n < 8 && !bus.done) begin
        step(I_NONE, 0, 0, 0);
        n++;
      end
      check("ovf_done_seen", 32'(bus.done), 32'd1);
      check("ovf_done_latency", 32'(n), 32'd1);
    end
    check("ovf_accepted", 32'(bus.accepted), 32'd0);
    check("ovf_err_sticky", 32'(bus.inflight_error), 32'd1);
    step(I_NONE, 0, 0, 0);
    check("ovf_idle", 32'(bus.dbg_state), 32'(IDLE));
    check("ovf_done_pulse", 32'(bus.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
